// File: rtl/cp0_nested_if.sv
// Bus bundle between the fetch stage and the CP0 interrupt controller.
interface cp0_nested_if #(
    parameter int N_IRQ = 8
);
    logic [31:0]      current_pc;
    logic [N_IRQ-1:0] hardware_interrupt;
    logic             eret;
    logic             csr_we;
    logic [31:0]      csr_wdata;
    logic             pc_jump;
    logic [31:0]      pc_addr;
    logic             writeback_mask;
    logic [31:0]      status;
    logic [31:0]      epc;
    logic             interrupt;

    modport master (
        output current_pc, hardware_interrupt, eret, csr_we, csr_wdata,
        input  pc_jump, pc_addr, writeback_mask, status, epc, interrupt
    );

    modport slave (
        input  current_pc, hardware_interrupt, eret, csr_we, csr_wdata,
        output pc_jump, pc_addr, writeback_mask, status, epc, interrupt
    );
endinterface

// File: rtl/cp0_nested.sv
// CP0 interrupt controller: edge-latched pending lines, priority select,
// nested service through an EPC/level stack, ERET unwinding.
module cp0_nested #(
    parameter int          N_IRQ      = 8,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic         clk,
    input  logic         clr,
    cp0_nested_if.slave  bus
);
    localparam int LW = 5;
    localparam int DW = 4;

    logic [N_IRQ-1:0] irq_q, irq_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic             gie_q, gie_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [LW-1:0]    cur_lvl_q, cur_lvl_d;
    logic [31:0]      epc_stk_q [DEPTH];
    logic [31:0]      epc_stk_d [DEPTH];
    logic [LW-1:0]    lvl_stk_q [DEPTH];
    logic [LW-1:0]    lvl_stk_d [DEPTH];
    logic             pc_jump_q, pc_jump_d;
    logic [31:0]      pc_addr_q, pc_addr_d;
    logic             wbm_q, wbm_d;

    logic [N_IRQ-1:0] rise, cand, sel_oh;
    logic [LW-1:0]    sel;
    logic [31:0]      top_epc;
    logic [LW-1:0]    top_lvl;
    logic             do_eret, take;
    logic             unused_wdata;

    // Only the mask field and the global-enable bit of the write data matter.
    assign unused_wdata = ^bus.csr_wdata[30:N_IRQ];

    // Next-state: edge detect, priority pick, take/ERET arbitration, stack update.
    always_comb begin
        rise = bus.hardware_interrupt & ~irq_q;
        cand = pending_q & mask_q;

        sel = LW'(N_IRQ);
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) sel = LW'(i);
        end

        top_epc = 32'h0;
        top_lvl = LW'(N_IRQ);
        for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i + 1) == depth_q) begin
                top_epc = epc_stk_q[i];
                top_lvl = lvl_stk_q[i];
            end
        end

        do_eret = bus.eret && (depth_q != '0);
        // The cycle right after a redirect never takes, so the fetch stage
        // sees at most one redirect per two cycles from an interrupt.
        take = gie_q && (cand != '0) && (sel < cur_lvl_q) &&
               (depth_q < DW'(DEPTH)) && !bus.eret && !pc_jump_q;

        for (int i = 0; i < N_IRQ; i++) begin
            sel_oh[i] = take && (sel == LW'(i));
        end

        // A new edge in the same cycle as the take re-arms the line.
        irq_d     = bus.hardware_interrupt;
        pending_d = (pending_q & ~sel_oh) | rise;
        mask_d    = mask_q;
        gie_d     = gie_q;
        depth_d   = depth_q;
        cur_lvl_d = cur_lvl_q;
        epc_stk_d = epc_stk_q;
        lvl_stk_d = lvl_stk_q;
        pc_jump_d = 1'b0;
        pc_addr_d = 32'h0;
        wbm_d     = 1'b0;

        if (bus.csr_we) begin
            mask_d = bus.csr_wdata[N_IRQ-1:0];
            gie_d  = bus.csr_wdata[31];
        end

        if (do_eret) begin
            depth_d   = depth_q - DW'(1);
            cur_lvl_d = top_lvl;
            pc_jump_d = 1'b1;
            pc_addr_d = top_epc;
        end else if (take) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (DW'(i) == depth_q) begin
                    epc_stk_d[i] = bus.current_pc;
                    lvl_stk_d[i] = cur_lvl_q;
                end
            end
            depth_d   = depth_q + DW'(1);
            cur_lvl_d = sel;
            pc_jump_d = 1'b1;
            pc_addr_d = VEC_BASE + 32'(sel) * VEC_STRIDE;
            wbm_d     = 1'b1;
        end
    end

    // State and registered outputs; reset discards pending lines and the stack.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            depth_q   <= '0;
            cur_lvl_q <= LW'(N_IRQ);
            for (int i = 0; i < DEPTH; i++) begin
                epc_stk_q[i] <= 32'h0;
                lvl_stk_q[i] <= '0;
            end
            pc_jump_q <= 1'b0;
            pc_addr_q <= 32'h0;
            wbm_q     <= 1'b0;
        end else begin
            irq_q     <= irq_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            depth_q   <= depth_d;
            cur_lvl_q <= cur_lvl_d;
            epc_stk_q <= epc_stk_d;
            lvl_stk_q <= lvl_stk_d;
            pc_jump_q <= pc_jump_d;
            pc_addr_q <= pc_addr_d;
            wbm_q     <= wbm_d;
        end
    end

    assign bus.pc_jump        = pc_jump_q;
    assign bus.pc_addr        = pc_addr_q;
    assign bus.writeback_mask = wbm_q;
    assign bus.status         = {gie_q, 3'b000, depth_q, 3'b000, cur_lvl_q, 16'(mask_q)};
    assign bus.epc            = top_epc;
    assign bus.interrupt      = (depth_q != '0);
endmodule

// File: tb/tb_cp0_nested.sv
// Directed bench for cp0_nested: vector table for the DEPTH=4 instance,
// hand sequences for stack-full (DEPTH=2) and asynchronous reset mid-nest.
module tb_cp0_nested;
    logic clk;
    logic clr_a, clr_b;
    int   checks;
    int   failures;

    cp0_nested_if #(.N_IRQ(8)) ifa ();
    cp0_nested_if #(.N_IRQ(8)) ifb ();

    cp0_nested #(.N_IRQ(8), .DEPTH(4)) dut_a (.clk(clk), .clr(clr_a), .bus(ifa));
    cp0_nested #(.N_IRQ(8), .DEPTH(2)) dut_b (.clk(clk), .clr(clr_b), .bus(ifb));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  irq;
        logic [31:0] pc;
        logic        eret;
        logic        we;
        logic [31:0] wd;
        logic        jmp;
        logic [31:0] addr;
        logic        wbm;
        logic [31:0] epc;
        logic        intr;
        logic [31:0] st;
    } vec_t;

    localparam int NV = 25;
    vec_t tv [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic step_b(input logic [7:0] irq, input logic [31:0] pc,
                          input logic er, input logic we, input logic [31:0] wd);
        ifb.hardware_interrupt = irq;
        ifb.current_pc         = pc;
        ifb.eret               = er;
        ifb.csr_we             = we;
        ifb.csr_wdata          = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        clr_a    = 1'b0;
        clr_b    = 1'b0;
        ifa.hardware_interrupt = '0; ifa.current_pc = '0; ifa.eret = 1'b0;
        ifa.csr_we = 1'b0; ifa.csr_wdata = '0;
        ifb.hardware_interrupt = '0; ifb.current_pc = '0; ifb.eret = 1'b0;
        ifb.csr_we = 1'b0; ifb.csr_wdata = '0;

        //        irq    pc         er    we    wd            jmp   addr       wbm   epc        int   status
        tv[0]  = '{8'h00, 32'h000, 1'b0, 1'b1, 32'h800000FF, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h800800FF};
        tv[1]  = '{8'h08, 32'h100, 1'b0, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h800800FF};
        tv[2]  = '{8'h08, 32'h100, 1'b0, 1'b0, 32'h0,        1'b1, 32'h830, 1'b1, 32'h100, 1'b1, 32'h810300FF};
        tv[3]  = '{8'h0A, 32'h834, 1'b0, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h100, 1'b1, 32'h810300FF};
        tv[4]  = '{8'h0A, 32'h834, 1'b0, 1'b0, 32'h0,        1'b1, 32'h810, 1'b1, 32'h834, 1'b1, 32'h820100FF};
        tv[5]  = '{8'h2A, 32'h838, 1'b0, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h834, 1'b1, 32'h820100FF};
        tv[6]  = '{8'h2A, 32'h83C, 1'b0, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h834, 1'b1, 32'h820100FF};
        tv[7]  = '{8'h2A, 32'h83C, 1'b1, 1'b0, 32'h0,        1'b1, 32'h834, 1'b0, 32'h100, 1'b1, 32'h810300FF};
        tv[8]  = '{8'h2A, 32'h83C, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 32'h800800FF};
        tv[9]  = '{8'h2A, 32'h200, 1'b0, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h800800FF};
        tv[10] = '{8'h2A, 32'h200, 1'b0, 1'b0, 32'h0,        1'b1, 32'h850, 1'b1, 32'h200, 1'b1, 32'h810500FF};
        tv[11] = '{8'h2E, 32'h204, 1'b0, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h200, 1'b1, 32'h810500FF};
        tv[12] = '{8'h2E, 32'h204, 1'b1, 1'b0, 32'h0,        1'b1, 32'h200, 1'b0, 32'h000, 1'b0, 32'h800800FF};
        tv[13] = '{8'h2E, 32'h300, 1'b0, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h800800FF};
        tv[14] = '{8'h2E, 32'h300, 1'b0, 1'b0, 32'h0,        1'b1, 32'h820, 1'b1, 32'h300, 1'b1, 32'h810200FF};
        tv[15] = '{8'h2E, 32'h304, 1'b1, 1'b0, 32'h0,        1'b1, 32'h300, 1'b0, 32'h000, 1'b0, 32'h800800FF};
        tv[16] = '{8'h2E, 32'h304, 1'b1, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h800800FF};
        tv[17] = '{8'h00, 32'h000, 1'b0, 1'b1, 32'h00000000, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h00080000};
        tv[18] = '{8'h04, 32'h000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h00080000};
        tv[19] = '{8'h04, 32'h000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h00080000};
        tv[20] = '{8'h04, 32'h000, 1'b0, 1'b1, 32'h80000000, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h80080000};
        tv[21] = '{8'h04, 32'h000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h80080000};
        tv[22] = '{8'h04, 32'h000, 1'b0, 1'b1, 32'h7FFFFF04, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h00080004};
        tv[23] = '{8'h04, 32'h000, 1'b0, 1'b1, 32'h80000004, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h80080004};
        tv[24] = '{8'h04, 32'h400, 1'b0, 1'b0, 32'h0,        1'b1, 32'h820, 1'b1, 32'h400, 1'b1, 32'h81020004};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.jump",   32'(ifa.pc_jump),        32'h0);
        chk("rst.addr",   ifa.pc_addr,             32'h0);
        chk("rst.wbm",    32'(ifa.writeback_mask), 32'h0);
        chk("rst.epc",    ifa.epc,                 32'h0);
        chk("rst.intr",   32'(ifa.interrupt),      32'h0);
        chk("rst.status", ifa.status,              32'h00080000);
        clr_a = 1'b1;
        clr_b = 1'b1;

        // Table-driven sequence on the DEPTH=4 instance
        for (int i = 0; i < NV; i++) begin
            ifa.hardware_interrupt = tv[i].irq;
            ifa.current_pc         = tv[i].pc;
            ifa.eret               = tv[i].eret;
            ifa.csr_we             = tv[i].we;
            ifa.csr_wdata          = tv[i].wd;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.jump", i),   32'(ifa.pc_jump),        32'(tv[i].jmp));
            if (tv[i].jmp)
                chk($sformatf("v%0d.addr", i), ifa.pc_addr,           tv[i].addr);
            chk($sformatf("v%0d.wbm", i),    32'(ifa.writeback_mask), 32'(tv[i].wbm));
            chk($sformatf("v%0d.epc", i),    ifa.epc,                 tv[i].epc);
            chk($sformatf("v%0d.intr", i),   32'(ifa.interrupt),      32'(tv[i].intr));
            chk($sformatf("v%0d.status", i), ifa.status,              tv[i].st);
        end

        // Asynchronous reset while an interrupt is being served
        ifa.csr_we = 1'b0;
        clr_a = 1'b0;
        #1;
        chk("arst.jump",   32'(ifa.pc_jump),        32'h0);
        chk("arst.addr",   ifa.pc_addr,             32'h0);
        chk("arst.wbm",    32'(ifa.writeback_mask), 32'h0);
        chk("arst.epc",    ifa.epc,                 32'h0);
        chk("arst.intr",   32'(ifa.interrupt),      32'h0);
        chk("arst.status", ifa.status,              32'h00080000);
        ifa.hardware_interrupt = '0;
        @(posedge clk);
        #1;
        clr_a = 1'b1;
        ifa.hardware_interrupt = 8'h04;
        repeat (3) @(posedge clk);
        #1;
        chk("arst.after.jump",   32'(ifa.pc_jump), 32'h0);
        chk("arst.after.status", ifa.status,       32'h00080000);

        // Stack full on the DEPTH=2 instance
        step_b(8'h00, 32'h00, 1'b0, 1'b1, 32'h800000FF);
        step_b(8'h80, 32'h10, 1'b0, 1'b0, 32'h0);
        chk("b.l7.wait", 32'(ifb.pc_jump), 32'h0);
        step_b(8'h80, 32'h10, 1'b0, 1'b0, 32'h0);
        chk("b.l7.jump", 32'(ifb.pc_jump), 32'h1);
        chk("b.l7.addr", ifb.pc_addr,      32'h870);
        chk("b.l7.epc",  ifb.epc,          32'h10);
        step_b(8'hA0, 32'h20, 1'b0, 1'b0, 32'h0);
        step_b(8'hA0, 32'h20, 1'b0, 1'b0, 32'h0);
        chk("b.l5.jump",   32'(ifb.pc_jump), 32'h1);
        chk("b.l5.addr",   ifb.pc_addr,      32'h850);
        chk("b.l5.epc",    ifb.epc,          32'h20);
        chk("b.l5.status", ifb.status,       32'h820500FF);
        step_b(8'hA8, 32'h30, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step_b(8'hA8, 32'h30, 1'b0, 1'b0, 32'h0);
            chk($sformatf("b.full%0d.jump", k),   32'(ifb.pc_jump), 32'h0);
            chk($sformatf("b.full%0d.status", k), ifb.status,       32'h820500FF);
        end
        step_b(8'hA8, 32'h30, 1'b1, 1'b0, 32'h0);
        chk("b.eret.jump",   32'(ifb.pc_jump), 32'h1);
        chk("b.eret.addr",   ifb.pc_addr,      32'h20);
        chk("b.eret.status", ifb.status,       32'h810700FF);
        step_b(8'hA8, 32'h40, 1'b0, 1'b0, 32'h0);
        chk("b.hold.jump", 32'(ifb.pc_jump), 32'h0);
        step_b(8'hA8, 32'h40, 1'b0, 1'b0, 32'h0);
        chk("b.l3.jump",   32'(ifb.pc_jump), 32'h1);
        chk("b.l3.addr",   ifb.pc_addr,      32'h830);
        chk("b.l3.epc",    ifb.epc,          32'h40);
        chk("b.l3.status", ifb.status,       32'h820300FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cp0_nested.md
Name: cp0_nested

Overview:
- Parametrised coprocessor-0 interrupt controller for the MIPS core.
- Latches N_IRQ hardware interrupt lines and picks the highest-priority enabled one.
- Supports nested interrupts through an EPC stack with a saved-level stack; ERET returns to the interrupted code.
- Sits beside the PC/fetch stage and drives PC redirect and writeback squash.

Parameters:
- N_IRQ, 8: number of interrupt lines, 1..16; index 0 is the highest priority.
- DEPTH, 4: EPC/level stack entries, i.e. the maximum nesting, 1..15.
- VEC_BASE, 32'h0000_0800: handler address for line 0.
- VEC_STRIDE, 32'h0000_0010: address spacing between handler vectors.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- current_pc  in  32  PC of the instruction that will be interrupted.
- hardware_interrupt  in  N_IRQ  raw interrupt request lines.
- eret  in  1  return-from-exception strobe, one cycle.
- csr_we  in  1  write strobe for the status register.
- csr_wdata  in  32  write data: bits [N_IRQ-1:0] = mask, bit 31 = global enable.
- pc_jump  out  1  PC redirect valid, one-cycle pulse.
- pc_addr  out  32  redirect target.
- writeback_mask  out  1  squash writeback of the instruction at current_pc.
- status  out  32  status register, layout in Behaviour.
- epc  out  32  top of the EPC stack; 0 when the stack is empty.
- interrupt  out  1  high while depth > 0.

Behaviour:
- Reset (clr=0):
  - pending, mask, gie, depth and all stack entries clear to 0; cur_lvl = N_IRQ (idle).
  - All outputs are 0.
- Pending latch:
  - A registered copy of the lines is kept.
  - A rising edge on line i sets pending[i].
  - pending[i] clears only in the cycle line i is taken. The set takes priority if a new edge arrives in that same cycle.
- Candidate selection: cand = pending & mask. sel = lowest set index of cand.
- Take condition:
  - gie=1 and cand≠0 and sel < cur_lvl and depth < DEPTH and eret=0.
  - When taken, at the next posedge:
    - push {current_pc, cur_lvl}; depth += 1; cur_lvl = sel; clear pending[sel];
    - pc_jump=1, pc_addr = VEC_BASE + sel*VEC_STRIDE (32-bit, wrap ignored), writeback_mask=1.
- ERET:
  - If depth > 0: pop; cur_lvl = saved level; depth -= 1; pc_jump=1, pc_addr = popped EPC, writeback_mask=0.
  - If depth = 0: ignored; outputs stay 0.
- Eret and a takeable interrupt in the same cycle: eret wins. The interrupt stays pending and is re-evaluated next cycle against the restored level (tail-chain).
- Output timing:
  - Decisions are registered; outputs are valid 1 cycle after the sampling posedge.
  - pc_jump and writeback_mask deassert on the next cycle unless a new event occurs.
  - No take is allowed in the cycle immediately after a pc_jump; the request is held pending.
- Stack full (depth = DEPTH): further interrupts remain pending and nothing is lost.
- Equal or lower priority than cur_lvl: held pending until the level drops.
- CSR write:
  - csr_we updates mask and gie at the posedge.
  - A take evaluated in the same cycle uses the old values.
  - Bits of csr_wdata outside the mask and bit 31 are ignored.
- Status layout:
  - [15:0] mask, zero-extended;
  - [20:16] cur_lvl;
  - [27:24] depth;
  - [31] gie;
  - all other bits 0.
- epc and interrupt are combinational from the registered stack top and depth.
- Reset mid-operation: everything returns to reset values immediately. Pending interrupts and stack contents are discarded.

Test Plan:
- Reset, then csr write 32'h8000_00FF, then a rising edge on line 3 with current_pc=0x100 -> next cycle pc_jump=1, pc_addr=0x830, writeback_mask=1, epc=0x100, interrupt=1, status[20:16]=3.
- While serving line 3, raise line 1 at pc=0x834 -> jump to 0x810, depth=2, epc=0x834. ERET -> pc_addr=0x834, depth=1. ERET -> pc_addr=0x100, interrupt=0.
- While serving line 1, raise line 5 -> no jump. After ERET returns to level N_IRQ, the next cycle jumps to 0x850.
- DEPTH=2 with three successively higher-priority edges -> third stays pending and is taken only after one ERET.
- Eret and a new edge in the same cycle -> that cycle only the ERET jump occurs; the interrupt jumps on a following cycle. An ERET with depth=0 -> no pc_jump.
- Mask=0 or gie=0 with an edge on line 2 -> no jump. After a csr write enabling it -> jump to 0x820. Assert clr=0 mid-nest -> all outputs 0 immediately.
